// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type encoding, port sizing, type-field
// position, port index names, allocator FSM states and an index wrap helper.
package noc_pkg;

    localparam int N_PORTS    = 5;
    localparam int FLIT_WIDTH = 34;
    localparam int IDX_W      = 3;

    // Flit type lives in the two most significant bits of every flit
    localparam int TYPE_MSB = FLIT_WIDTH - 1;
    localparam int TYPE_LSB = FLIT_WIDTH - 2;

    // Input port indices
    localparam int PORT_NORTH = 0;
    localparam int PORT_SOUTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_WEST  = 3;
    localparam int PORT_LOCAL = 4;

    typedef enum logic [1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // (base + ofs) mod n, valid for base < n and ofs <= n
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned ofs,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + ofs;
        if (sum >= n) begin
            sum = sum - n;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   elig_i       : per-input eligibility
//   rr_ptr_i     : index that has highest priority this round
//   winner_o     : one-hot winner (0 when nothing eligible)
//   winner_idx_o : index of the winner (0 when nothing eligible)
//   any_o        : at least one input is eligible
module rr_arbiter #(
    parameter int N_PORTS = noc_pkg::N_PORTS,
    parameter int IDX_W   = noc_pkg::IDX_W
) (
    input  logic [N_PORTS-1:0] elig_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [N_PORTS-1:0] winner_o,
    output logic [IDX_W-1:0]   winner_idx_o,
    output logic               any_o
);
    import noc_pkg::*;

    logic [IDX_W-1:0] pos_s;

    // Scan rr_ptr, rr_ptr+1, ... (mod N_PORTS); the first eligible index wins
    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        any_o        = 1'b0;
        pos_s        = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            pos_s = IDX_W'(wrap_add(32'(rr_ptr_i), 32'(k), 32'(N_PORTS)));
            if (!any_o && elig_i[pos_s]) begin
                any_o           = 1'b1;
                winner_idx_o    = pos_s;
                winner_o[pos_s] = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Switch allocator for one router output port. Shares the port among the
// inputs round-robin, holds a wormhole lock from head to tail, and muxes the
// owner's flit onto the output channel.
//   clk, arst       : clock, asynchronous active-low reset
//   req_i, valid_i  : per-input route bit for this port / flit valid
//   flit_i          : input i flit at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   ready_o         : per-input accept (handshake with valid_i)
//   out_valid_o, out_flit_o, out_ready_i : downstream channel
//   grant_o, grant_idx_o : lock owner (one-hot / index), 0 when idle
//   busy_o          : lock held
//   proto_err_o     : one-cycle pulse on a flit-type protocol violation
module output_port_arbiter #(
    parameter int N_PORTS    = noc_pkg::N_PORTS,
    parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH,
    parameter int IDX_W      = noc_pkg::IDX_W
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [N_PORTS-1:0]            req_i,
    input  logic [N_PORTS-1:0]            valid_i,
    input  logic [N_PORTS*FLIT_WIDTH-1:0] flit_i,
    output logic [N_PORTS-1:0]            ready_o,
    output logic                          out_valid_o,
    output logic [FLIT_WIDTH-1:0]         out_flit_o,
    input  logic                          out_ready_i,
    output logic [N_PORTS-1:0]            grant_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic                          busy_o,
    output logic                          proto_err_o
);
    import noc_pkg::*;

    arb_state_t             state_q, state_d;
    logic [N_PORTS-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   first_done_q, first_done_d;
    logic                   proto_err_q, proto_err_d;

    logic [FLIT_WIDTH-1:0]  flit_s [N_PORTS];
    flit_type_t             type_s [N_PORTS];
    logic [N_PORTS-1:0]     elig_s;
    logic [N_PORTS-1:0]     stray_s;
    logic [N_PORTS-1:0]     win_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   win_any_s;

    logic [FLIT_WIDTH-1:0]  own_flit_s;
    flit_type_t             own_type_s;
    logic                   own_valid_s;
    logic                   xfer_s;
    logic [N_PORTS-1:0]     ready_s;
    logic                   out_valid_s;
    logic [FLIT_WIDTH-1:0]  out_flit_s;

    // Split the flit bus and classify each requesting input
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            flit_s[i]  = flit_i[i*FLIT_WIDTH +: FLIT_WIDTH];
            type_s[i]  = flit_type_t'(flit_s[i][FLIT_WIDTH-1 -: 2]);
            elig_s[i]  = req_i[i] & valid_i[i] &
                         ((type_s[i] == FT_HEAD) || (type_s[i] == FT_SINGLE));
            // Mid-packet flit asking for an unlocked port
            stray_s[i] = req_i[i] & valid_i[i] &
                         ((type_s[i] == FT_BODY) || (type_s[i] == FT_TAIL));
        end
    end

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr (
        .elig_i       (elig_s),
        .rr_ptr_i     (rr_ptr_q),
        .winner_o     (win_s),
        .winner_idx_o (win_idx_s),
        .any_o        (win_any_s)
    );

    // Lock FSM: next state, channel mux and protocol checks
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_idx_d  = grant_idx_q;
        rr_ptr_d     = rr_ptr_q;
        first_done_d = first_done_q;
        proto_err_d  = 1'b0;
        ready_s      = '0;
        out_valid_s  = 1'b0;
        out_flit_s   = '0;
        own_flit_s   = flit_s[grant_idx_q];
        own_type_s   = type_s[grant_idx_q];
        own_valid_s  = valid_i[grant_idx_q];
        xfer_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                proto_err_d = |stray_s;
                if (win_any_s) begin
                    state_d      = ST_LOCKED;
                    grant_d      = win_s;
                    grant_idx_d  = win_idx_s;
                    first_done_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                out_valid_s          = own_valid_s;
                out_flit_s           = own_flit_s;
                ready_s[grant_idx_q] = out_ready_i;
                xfer_s               = own_valid_s & out_ready_i;
                if (xfer_s) begin
                    first_done_d = 1'b1;
                    // A second head inside one lock is passed through but flagged
                    proto_err_d  = first_done_q && (own_type_s == FT_HEAD);
                    if ((own_type_s == FT_TAIL) || (own_type_s == FT_SINGLE)) begin
                        state_d     = ST_IDLE;
                        grant_d     = '0;
                        grant_idx_d = '0;
                        rr_ptr_d    = IDX_W'(wrap_add(32'(grant_idx_q), 32'd1, 32'(N_PORTS)));
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        endcase
    end

    // State and lock registers
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            rr_ptr_q     <= '0;
            first_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            first_done_q <= first_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign ready_o     = ready_s;
    assign out_valid_o = out_valid_s;
    assign out_flit_o  = out_flit_s;
    assign grant_o     = grant_q;
    assign grant_idx_o = grant_idx_q;
    assign busy_o      = (state_q == ST_LOCKED);
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: a vector table for grant, round
// robin, lock and idle-error behaviour, plus hand sequences for reset,
// backpressure, head-in-lock error and reset during a packet.
module tb_output_port_arbiter;

    localparam int NP = 5;
    localparam int FW = 34;
    localparam int IW = 3;

    localparam logic [1:0] TH = 2'b00;
    localparam logic [1:0] TB = 2'b01;
    localparam logic [1:0] TT = 2'b10;
    localparam logic [1:0] TS = 2'b11;

    logic               clk = 1'b0;
    logic               arst;
    logic [NP-1:0]      req_i;
    logic [NP-1:0]      valid_i;
    logic [NP*FW-1:0]   flit_i;
    logic [NP-1:0]      ready_o;
    logic               out_valid_o;
    logic [FW-1:0]      out_flit_o;
    logic               out_ready_i;
    logic [NP-1:0]      grant_o;
    logic [IW-1:0]      grant_idx_o;
    logic               busy_o;
    logic               proto_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string         nm;
        logic [NP-1:0] req;
        logic [NP-1:0] valid;
        logic [9:0]    types;
        logic [NP-1:0] exp_grant;
        logic          exp_err;
    } vec_t;

    vec_t tbl[$];

    output_port_arbiter dut (
        .clk         (clk),
        .arst        (arst),
        .req_i       (req_i),
        .valid_i     (valid_i),
        .flit_i      (flit_i),
        .ready_o     (ready_o),
        .out_valid_o (out_valid_o),
        .out_flit_o  (out_flit_o),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .grant_idx_o (grant_idx_o),
        .busy_o      (busy_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ft(input int i, input logic [1:0] t);
        logic [9:0] r;
        r = 10'd0;
        r[2*i +: 2] = t;
        return r;
    endfunction

    function automatic vec_t mk(input string nm, input logic [NP-1:0] rq,
                                input logic [NP-1:0] vl, input logic [9:0] ty,
                                input logic [NP-1:0] eg, input logic ee);
        vec_t v;
        v.nm = nm; v.req = rq; v.valid = vl; v.types = ty;
        v.exp_grant = eg; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [NP-1:0] rq, input logic [NP-1:0] vl,
                         input logic [9:0] ty, input logic ordy, input logic [15:0] tag);
        req_i       = rq;
        valid_i     = vl;
        out_ready_i = ordy;
        for (int i = 0; i < NP; i++) begin
            flit_i[i*FW +: FW] = {ty[2*i +: 2], 8'hC0 + 8'(i), 8'h5A, tag};
        end
    endtask

    // Expected channel outputs follow from the expected owner and the
    // inputs currently driven by the bench.
    task automatic check_outputs(input string nm, input logic [NP-1:0] eg, input logic ee);
        int g = 0;
        logic [FW-1:0] ef;
        for (int i = 0; i < NP; i++) begin
            if (eg[i]) g = i;
        end
        ef = (eg != 5'd0) ? flit_i[g*FW +: FW] : '0;
        chk({nm, ".grant"}, 64'(grant_o),     64'(eg));
        chk({nm, ".idx"},   64'(grant_idx_o), 64'(g));
        chk({nm, ".busy"},  64'(busy_o),      64'(eg != 5'd0));
        chk({nm, ".ready"}, 64'(ready_o),     64'(eg & {NP{out_ready_i}}));
        chk({nm, ".oval"},  64'(out_valid_o), 64'(|(eg & valid_i)));
        chk({nm, ".oflit"}, 64'(out_flit_o),  64'(ef));
        chk({nm, ".err"},   64'(proto_err_o), 64'(ee));
    endtask

    task automatic step(input string nm, input logic [NP-1:0] eg, input logic ee);
        @(posedge clk);
        #1;
        check_outputs(nm, eg, ee);
    endtask

    initial begin
        logic [9:0] rr_ty;
        logic [9:0] pq_ty;

        // ---------------- vector table ----------------
        rr_ty = ft(0, TS) | ft(1, TS) | ft(4, TS);
        tbl.push_back(mk("rr_g0",  5'b10011, 5'b10011, rr_ty, 5'b00001, 1'b0));
        tbl.push_back(mk("rr_b0",  5'b10011, 5'b10011, rr_ty, 5'b00000, 1'b0));
        tbl.push_back(mk("rr_g1",  5'b10011, 5'b10011, rr_ty, 5'b00010, 1'b0));
        tbl.push_back(mk("rr_b1",  5'b10011, 5'b10011, rr_ty, 5'b00000, 1'b0));
        tbl.push_back(mk("rr_g4",  5'b10011, 5'b10011, rr_ty, 5'b10000, 1'b0));
        tbl.push_back(mk("rr_b4",  5'b10011, 5'b10011, rr_ty, 5'b00000, 1'b0));
        tbl.push_back(mk("rr_g0b", 5'b10011, 5'b10011, rr_ty, 5'b00001, 1'b0));
        tbl.push_back(mk("rr_b0b", 5'b10011, 5'b10011, rr_ty, 5'b00000, 1'b0));
        tbl.push_back(mk("rr_g1b", 5'b10011, 5'b10011, rr_ty, 5'b00010, 1'b0));
        tbl.push_back(mk("rr_b1b", 5'b10011, 5'b10011, rr_ty, 5'b00000, 1'b0));
        // request without valid, valid without request: nothing eligible
        tbl.push_back(mk("noelig", 5'b00001, 5'b00100, ft(2, TH), 5'b00000, 1'b0));
        // single packet on input 2 (pointer now 2)
        tbl.push_back(mk("pk_gnt",  5'b00100, 5'b00100, ft(2, TH), 5'b00100, 1'b0));
        tbl.push_back(mk("pk_head", 5'b00100, 5'b00100, ft(2, TH), 5'b00100, 1'b0));
        tbl.push_back(mk("pk_body", 5'b00100, 5'b00100, ft(2, TB), 5'b00100, 1'b0));
        tbl.push_back(mk("pk_tail", 5'b00100, 5'b00100, ft(2, TT), 5'b00000, 1'b0));
        tbl.push_back(mk("pk_gap",  5'b00000, 5'b00000, ft(2, TT), 5'b00000, 1'b0));
        // pointer is 3 after the tail of input 2
        pq_ty = ft(2, TS) | ft(3, TS);
        tbl.push_back(mk("ptr_g3", 5'b01100, 5'b01100, pq_ty, 5'b01000, 1'b0));
        tbl.push_back(mk("ptr_b3", 5'b01100, 5'b01100, pq_ty, 5'b00000, 1'b0));
        tbl.push_back(mk("ptr_g2", 5'b01100, 5'b01100, pq_ty, 5'b00100, 1'b0));
        tbl.push_back(mk("ptr_b2", 5'b01100, 5'b01100, pq_ty, 5'b00000, 1'b0));
        tbl.push_back(mk("ptr_z",  5'b00000, 5'b00000, pq_ty, 5'b00000, 1'b0));
        // stray BODY / TAIL while idle
        tbl.push_back(mk("err_body",  5'b00010, 5'b00010, ft(1, TB), 5'b00000, 1'b1));
        tbl.push_back(mk("err_body0", 5'b00000, 5'b00000, ft(1, TB), 5'b00000, 1'b0));
        tbl.push_back(mk("err_tail",  5'b00001, 5'b00001, ft(0, TT), 5'b00000, 1'b1));
        tbl.push_back(mk("err_tail0", 5'b00000, 5'b00000, ft(0, TT), 5'b00000, 1'b0));
        // wormhole lock: input 3 mid-packet, input 1 waits with a head
        tbl.push_back(mk("wh_g3",   5'b01000, 5'b01000, ft(3, TH),              5'b01000, 1'b0));
        tbl.push_back(mk("wh_h3",   5'b01010, 5'b01010, ft(3, TH) | ft(1, TH),  5'b01000, 1'b0));
        tbl.push_back(mk("wh_b3",   5'b01010, 5'b01010, ft(3, TB) | ft(1, TH),  5'b01000, 1'b0));
        tbl.push_back(mk("wh_t3",   5'b01010, 5'b01010, ft(3, TT) | ft(1, TH),  5'b00000, 1'b0));
        tbl.push_back(mk("wh_g1",   5'b00010, 5'b00010, ft(1, TH),              5'b00010, 1'b0));
        tbl.push_back(mk("wh_h1",   5'b00010, 5'b00010, ft(1, TH),              5'b00010, 1'b0));
        tbl.push_back(mk("wh_t1",   5'b00010, 5'b00010, ft(1, TT),              5'b00000, 1'b0));
        tbl.push_back(mk("wh_z",    5'b00000, 5'b00000, 10'd0,                  5'b00000, 1'b0));

        // ---------------- reset and idle ----------------
        arst = 1'b0;
        drive(5'b00100, 5'b00100, ft(2, TH), 1'b1, 16'h0001);
        repeat (3) step("rst", 5'b00000, 1'b0);
        drive(5'b00000, 5'b00000, 10'd0, 1'b1, 16'h0002);
        @(negedge clk);
        arst = 1'b1;
        repeat (10) step("idle", 5'b00000, 1'b0);

        // ---------------- table ----------------
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].req, tbl[k].valid, tbl[k].types, 1'b1, 16'(16'h1000 + k));
            step(tbl[k].nm, tbl[k].exp_grant, tbl[k].exp_err);
        end

        // ---------------- backpressure on input 0, then head inside lock ----------------
        drive(5'b00001, 5'b00001, ft(0, TH), 1'b0, 16'h2000);
        step("bp_gnt", 5'b00001, 1'b0);
        for (int c = 0; c < 4; c++) step("bp_hold", 5'b00001, 1'b0);
        out_ready_i = 1'b1;
        step("bp_head", 5'b00001, 1'b0);
        drive(5'b00001, 5'b00001, ft(0, TH), 1'b1, 16'h2001);
        step("bp_head2", 5'b00001, 1'b1);
        drive(5'b00001, 5'b00001, ft(0, TT), 1'b1, 16'h2002);
        step("bp_tail", 5'b00000, 1'b0);
        drive(5'b00000, 5'b00000, 10'd0, 1'b1, 16'h2003);
        step("bp_gap", 5'b00000, 1'b0);

        // ---------------- reset in mid-packet on input 4 ----------------
        drive(5'b10000, 5'b10000, ft(4, TH), 1'b1, 16'h3000);
        step("rm_gnt", 5'b10000, 1'b0);
        drive(5'b10000, 5'b10000, ft(4, TB), 1'b1, 16'h3001);
        step("rm_body", 5'b10000, 1'b0);
        #2;
        arst = 1'b0;
        #1;
        check_outputs("rm_async", 5'b00000, 1'b0);
        step("rm_hold", 5'b00000, 1'b0);
        @(negedge clk);
        arst = 1'b1;
        // pointer back at 0 so input 0 beats input 4
        drive(5'b10001, 5'b10001, ft(0, TS) | ft(4, TS), 1'b1, 16'h3002);
        step("rm_ptr0", 5'b00001, 1'b0);
        step("rm_done", 5'b00000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
